// File: rtl/nseq_pkg.sv
// Shared definitions for the NAND microsequencer: opcodes, FSM states,
// step counts and the per-opcode microsequence table.
package nseq_pkg;

  localparam logic [2:0] OP_NAND    = 3'd0;
  localparam logic [2:0] OP_NOT_A   = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [2:0] STEPS_NAND  = 3'd1;
  localparam logic [2:0] STEPS_NOT_A = 3'd1;
  localparam logic [2:0] STEPS_AND   = 3'd2;
  localparam logic [2:0] STEPS_OR    = 3'd3;
  localparam logic [2:0] STEPS_NOR   = 3'd4;
  localparam logic [2:0] STEPS_XOR   = 3'd4;
  localparam logic [2:0] STEPS_XNOR  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_T2} src_t;
  typedef enum logic [1:0] {DST_T0, DST_T1, DST_T2, DST_R} dst_t;

  typedef struct packed {
    src_t x;
    src_t y;
    dst_t dst;
  } ustep_t;

  function automatic logic [2:0] op_steps(input logic [2:0] op);
    case (op)
      OP_NAND:  return STEPS_NAND;
      OP_NOT_A: return STEPS_NOT_A;
      OP_AND:   return STEPS_AND;
      OP_OR:    return STEPS_OR;
      OP_NOR:   return STEPS_NOR;
      OP_XOR:   return STEPS_XOR;
      OP_XNOR:  return STEPS_XNOR;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic ustep_t mk(input src_t x, input src_t y, input dst_t d);
    ustep_t u;
    u.x   = x;
    u.y   = y;
    u.dst = d;
    return u;
  endfunction

  // Intermediate results of NOR/XNOR land in a spare temporary so the
  // visible rsp_data only changes on the final step.
  function automatic ustep_t micro(input logic [2:0] op, input logic [2:0] step);
    ustep_t u;
    u = mk(SRC_A, SRC_B, DST_R);
    case (op)
      OP_NOT_A: u = mk(SRC_A, SRC_A, DST_R);
      OP_AND: begin
        case (step)
          3'd0:    u = mk(SRC_A, SRC_B, DST_T0);
          default: u = mk(SRC_T0, SRC_T0, DST_R);
        endcase
      end
      OP_OR, OP_NOR: begin
        case (step)
          3'd0:    u = mk(SRC_A, SRC_A, DST_T0);
          3'd1:    u = mk(SRC_B, SRC_B, DST_T1);
          3'd2:    u = mk(SRC_T0, SRC_T1, (op == OP_OR) ? DST_R : DST_T2);
          default: u = mk(SRC_T2, SRC_T2, DST_R);
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (step)
          3'd0:    u = mk(SRC_A, SRC_B, DST_T0);
          3'd1:    u = mk(SRC_A, SRC_T0, DST_T1);
          3'd2:    u = mk(SRC_B, SRC_T0, DST_T2);
          3'd3:    u = mk(SRC_T1, SRC_T2, (op == OP_XOR) ? DST_R : DST_T0);
          default: u = mk(SRC_T0, SRC_T0, DST_R);
        endcase
      end
      default: u = mk(SRC_A, SRC_B, DST_R);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/nand_unit.sv
// W-bit combinational NAND; the single shared evaluation resource.
module nand_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = ~(a & b);

endmodule

// File: rtl/nand_seq_arb.sv
// Two-requester round-robin front end that evaluates Boolean ops as NAND
// microsequences. Optional NSEQ_USE_COUNT_EN adds a saturating nand_uses counter.
module nand_seq_arb
  import nseq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2:0]   req_op0,
  input  logic [2:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err
`ifdef NSEQ_USE_COUNT_EN
  ,
  output logic [15:0]  nand_uses
`endif
);

  state_t       state;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] t0, t1, t2;
  logic         id_q;
  logic [2:0]   step;
  logic         last_grant;

  logic [1:0]   grant;
  logic         gnt_id;
  logic [2:0]   op_sel;
  logic [W-1:0] a_sel, b_sel;
  ustep_t       us;
  logic [W-1:0] nx, ny, nout;
  logic         last_step;

  function automatic logic [W-1:0] pick(input src_t s, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] x0,
                                        input logic [W-1:0] x1, input logic [W-1:0] x2);
    case (s)
      SRC_A:   return a;
      SRC_B:   return b;
      SRC_T0:  return x0;
      SRC_T1:  return x1;
      default: return x2;
    endcase
  endfunction

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign gnt_id    = grant[1];
  assign req_ready = (state == S_IDLE && !reset) ? grant : 2'b00;

  always_comb begin
    op_sel = gnt_id ? req_op1 : req_op0;
    a_sel  = gnt_id ? req_a1  : req_a0;
    b_sel  = gnt_id ? req_b1  : req_b0;
  end

  always_comb begin
    us        = micro(op_q, step);
    nx        = pick(us.x, a_q, b_q, t0, t1, t2);
    ny        = pick(us.y, a_q, b_q, t0, t1, t2);
    last_step = (step == 3'(op_steps(op_q) - 3'd1));
  end

  nand_unit #(.W(W)) u_nand (
    .a (nx),
    .b (ny),
    .y (nout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      t0         <= '0;
      t1         <= '0;
      t2         <= '0;
      step       <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            op_q       <= op_sel;
            a_q        <= a_sel;
            b_q        <= b_sel;
            id_q       <= gnt_id;
            last_grant <= gnt_id;
            step       <= '0;
            if (op_sel == OP_ILLEGAL) begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_id    <= gnt_id;
              rsp_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          case (us.dst)
            DST_T0:  t0 <= nout;
            DST_T1:  t1 <= nout;
            DST_T2:  t2 <= nout;
            default: rsp_data <= nout;
          endcase
          step <= step + 3'd1;
          if (last_step) begin
            rsp_id    <= id_q;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NSEQ_USE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      nand_uses <= '0;
    else if (state == S_EXEC && nand_uses != 16'hFFFF)
      nand_uses <= nand_uses + 16'd1;
  end
`endif

endmodule

// File: tb/tb_nand_seq_arb.sv
// Randomised and directed bench for nand_seq_arb against a transaction-level model.
module tb_nand_seq_arb;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id, rsp_err;
`ifdef NSEQ_USE_COUNT_EN
  logic [15:0]  nand_uses;
`endif

  always #5 clk = ~clk;

  nand_seq_arb #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
`ifdef NSEQ_USE_COUNT_EN
    ,
    .nand_uses (nand_uses)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: a request is either absent, counting down its step budget, or
  // waiting for the consumer.
  bit           m_inflight = 0;
  int           m_rem = 0;
  logic [W-1:0] m_res = '0;
  bit           m_id = 0;
  bit           m_last = 1;
  int unsigned  m_uses = 0;
  bit           e_valid = 0;
  logic [W-1:0] e_data = '0;
  bit           e_id = 0;
  bit           e_err = 0;
  bit           chk_en = 0;
  logic [1:0]   rr_seen;

  int steps_tab [8] = '{1, 1, 2, 3, 4, 4, 5, 0};

  function automatic logic [W-1:0] ref_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return ~(a & b);
      3'd1:    return ~a;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_grant();
    if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  task automatic cycle();
    logic [1:0]   exp_rr;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    bit           g;
    @(negedge clk);
    if (chk_en) begin
      chk("rsp_valid", rsp_valid, e_valid);
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_err", rsp_err, e_err);
`ifdef NSEQ_USE_COUNT_EN
      chk("nand_uses", nand_uses, m_uses);
`endif
    end
    exp_rr  = (!reset && !e_valid && !m_inflight) ? model_grant() : 2'b00;
    rr_seen = req_ready;
    if (chk_en) chk("req_ready", req_ready, exp_rr);
    if (reset) begin
      e_valid = 0; m_inflight = 0; e_data = '0; e_id = 0; e_err = 0;
      m_last = 1; m_uses = 0;
    end else if (e_valid) begin
      if (rsp_ready) e_valid = 0;
    end else if (m_inflight) begin
      m_rem--;
      if (m_uses < 32'hFFFF) m_uses++;
      if (m_rem == 0) begin
        m_inflight = 0; e_valid = 1; e_data = m_res; e_id = m_id; e_err = 0;
      end
    end else if (exp_rr != 2'b00) begin
      g = exp_rr[1];
      m_last = g;
      op = g ? req_op1 : req_op0;
      a  = g ? req_a1 : req_a0;
      b  = g ? req_b1 : req_b0;
      if (op == 3'd7) begin
        e_valid = 1; e_data = '0; e_err = 1; e_id = g;
      end else begin
        m_res = ref_fn(op, a, b); m_rem = steps_tab[op]; m_inflight = 1; m_id = g;
      end
    end
    @(posedge clk);
    if (reset) chk_en = 1;
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_op(input bit id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_lat,
                       input logic [W-1:0] exp_data, input bit exp_err);
    int n;
    if (id) begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid = 2'b10;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid = 2'b01;
    end
    cycle();
    chk("accept", rr_seen, id ? 2'b10 : 2'b01);
    req_valid = 2'b00;
    wait_rsp(n);
    chk("latency", n, exp_lat);
    chk("op_data", rsp_data, exp_data);
    chk("op_id", rsp_id, id);
    chk("op_err", rsp_err, exp_err);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] gseq [$];
    int n;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);

    do_op(0, 3'd3, 4'b0011, 4'b0101, 3, 4'b0111, 0);
    do_op(1, 3'd5, 4'b1100, 4'b1010, 4, 4'b0110, 0);
    do_op(1, 3'd6, 4'b1100, 4'b1010, 5, 4'b1001, 0);
    do_op(0, 3'd7, 4'b1111, 4'b0000, 0, 4'b0000, 1);
    do_op(0, 3'd1, 4'b1010, 4'b0000, 1, 4'b0101, 0);
    do_op(1, 3'd4, 4'b0011, 4'b0101, 4, 4'b1000, 0);
    do_op(0, 3'd0, 4'b0110, 4'b1100, 1, 4'b1011, 0);
    do_op(1, 3'd2, 4'b0110, 4'b1100, 2, 4'b0100, 0);

    // Hold the response under backpressure while both requesters wait.
    req_op0 = 3'd2; req_a0 = 4'hF; req_b0 = 4'hF; req_valid = 2'b01;
    cycle();
    req_op1 = 3'd2; req_a1 = 4'hF; req_b1 = 4'hF; req_valid = 2'b11;
    wait_rsp(n);
    chk("hold_lat", n, 2);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 4'hF);
      chk("hold_id", rsp_id, 0);
      chk("hold_rr", rr_seen, 2'b00);
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    chk("release_idle", rsp_valid, 0);

    // Reset in the middle of a NOR drops it.
    req_op0 = 3'd4; req_a0 = 4'b0011; req_b0 = 4'b0101; req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_err", rsp_err, 0);
`ifdef NSEQ_USE_COUNT_EN
    chk("mid_rst_uses", nand_uses, 0);
`endif

    // Continuous tie: grants alternate starting with requester 0.
    req_op0 = 3'd2; req_op1 = 3'd2;
    req_a0 = 4'hF; req_b0 = 4'hF; req_a1 = 4'hF; req_b1 = 4'hF;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (rr_seen != 2'b00) gseq.push_back(rr_seen);
    end
    chk("tie_count", gseq.size(), 6);
    if (gseq.size() >= 4) begin
      chk("tie_g0", gseq[0], 2'b01);
      chk("tie_g1", gseq[1], 2'b10);
      chk("tie_g2", gseq[2], 2'b01);
      chk("tie_g3", gseq[3], 2'b10);
    end
`ifdef NSEQ_USE_COUNT_EN
    chk("tie_uses", nand_uses, 12);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req_op0   = 3'($urandom_range(0, 7));
      req_op1   = 3'($urandom_range(0, 7));
      req_a0    = W'($urandom);
      req_b0    = W'($urandom);
      req_a1    = W'($urandom);
      req_b1    = W'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
